// File: rtl/decode_if.sv
// Decode-stage bus: Decode-stage inputs, the writeback port and the registered ID/EX bundle.
// The master drives the Decode inputs and writeback; the slave (decode) drives the outputs.
interface decode_if;
   logic [63:0] PC_D;
   logic [31:0] Instr_D;
   logic        Flush_E;
   logic        Stall_E;
   logic        RegWrite_W;
   logic [4:0]  Rd_W;
   logic [63:0] Result_W;
   logic [4:0]  Rs1_D;
   logic [4:0]  Rs2_D;
   logic [63:0] RD1_E;
   logic [63:0] RD2_E;
   logic [63:0] ImmExt_E;
   logic [63:0] PC_E;
   logic [4:0]  Rs1_E;
   logic [4:0]  Rs2_E;
   logic [4:0]  Rd_E;
   logic        RegWrite_E;
   logic        MemWrite_E;
   logic        Branch_E;
   logic        Jump_E;
   logic        Jalr_E;
   logic        ALUSrc_E;
   logic        Word_E;
   logic        Illegal_E;
   logic [1:0]  ResultSrc_E;
   logic [3:0]  ALUControl_E;
   logic [2:0]  Funct3_E;

   modport master (
      output PC_D, Instr_D, Flush_E, Stall_E, RegWrite_W, Rd_W, Result_W,
      input  Rs1_D, Rs2_D, RD1_E, RD2_E, ImmExt_E, PC_E, Rs1_E, Rs2_E, Rd_E,
             RegWrite_E, MemWrite_E, Branch_E, Jump_E, Jalr_E, ALUSrc_E, Word_E,
             Illegal_E, ResultSrc_E, ALUControl_E, Funct3_E
   );

   modport slave (
      input  PC_D, Instr_D, Flush_E, Stall_E, RegWrite_W, Rd_W, Result_W,
      output Rs1_D, Rs2_D, RD1_E, RD2_E, ImmExt_E, PC_E, Rs1_E, Rs2_E, Rd_E,
             RegWrite_E, MemWrite_E, Branch_E, Jump_E, Jalr_E, ALUSrc_E, Word_E,
             Illegal_E, ResultSrc_E, ALUControl_E, Funct3_E
   );
endinterface

// File: rtl/decode.sv
// RV64I decode stage: register file with write-through, immediate generation, control decode and ID/EX register.
// Define ZBA_EN to decode the Zba address-generation instructions; otherwise they are flagged illegal.
module decode (
   input  logic    clk,
   input  logic    rst,
   decode_if.slave bus
);
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'b0000, ALU_SUB    = 4'b0001, ALU_AND    = 4'b0010,
      ALU_OR     = 4'b0011, ALU_XOR    = 4'b0100, ALU_SLT    = 4'b0101,
      ALU_SLTU   = 4'b0110, ALU_SLL    = 4'b0111, ALU_SRL    = 4'b1000,
      ALU_SRA    = 4'b1001, ALU_SH1ADD = 4'b1010, ALU_SH2ADD = 4'b1011,
      ALU_SH3ADD = 4'b1100, ALU_ADDUW  = 4'b1101, ALU_PASSB  = 4'b1110
   } alu_e;

   typedef struct packed {
      logic [63:0] rd1;
      logic [63:0] rd2;
      logic [63:0] imm;
      logic [63:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic        alu_src;
      logic        word;
      logic        illegal;
      logic [1:0]  result_src;
      logic [3:0]  alu_ctrl;
      logic [2:0]  funct3;
   } idex_t;

   logic [63:0] r_regs [32];
   idex_t       r_idex;
   idex_t       w_idex;

   logic [31:0] w_instr;
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [5:0]  w_funct6;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rd;
   logic [63:0] w_rd1;
   logic [63:0] w_rd2;
   logic [63:0] w_imm;
   logic        w_legal;
   logic        w_reg_write;
   logic        w_mem_write;
   logic        w_branch;
   logic        w_jump;
   logic        w_jalr;
   logic        w_alu_src;
   logic        w_word;
   logic [1:0]  w_result_src;
   alu_e        w_alu;

   assign w_instr  = bus.Instr_D;
   assign w_opcode = w_instr[6:0];
   assign w_rd     = w_instr[11:7];
   assign w_funct3 = w_instr[14:12];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];
   assign w_funct7 = w_instr[31:25];
   assign w_funct6 = w_instr[31:26];

   assign bus.Rs1_D = w_rs1;
   assign bus.Rs2_D = w_rs2;

   // Writeback in the same cycle bypasses the array so Decode never reads a stale value.
   always_comb begin
      w_rd1 = r_regs[w_rs1];
      if (w_rs1 == 5'd0)
         w_rd1 = '0;
      else if (bus.RegWrite_W && (bus.Rd_W == w_rs1))
         w_rd1 = bus.Result_W;
      w_rd2 = r_regs[w_rs2];
      if (w_rs2 == 5'd0)
         w_rd2 = '0;
      else if (bus.RegWrite_W && (bus.Rd_W == w_rs2))
         w_rd2 = bus.Result_W;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++)
            r_regs[i] <= '0;
      end else if (bus.RegWrite_W && (bus.Rd_W != 5'd0)) begin
         r_regs[bus.Rd_W] <= bus.Result_W;
      end
   end

   always_comb begin
      case (w_opcode)
         OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR:
            w_imm = {{52{w_instr[31]}}, w_instr[31:20]};
         OPC_STORE:
            w_imm = {{52{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         OPC_BRANCH:
            w_imm = {{51{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            w_imm = {{32{w_instr[31]}}, w_instr[31:12], 12'b0};
         OPC_JAL:
            w_imm = {{43{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
         default:
            w_imm = '0;
      endcase
   end

   always_comb begin
      w_legal      = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
      w_jalr       = 1'b0;
      w_alu_src    = 1'b0;
      w_word       = 1'b0;
      w_result_src = 2'b00;
      w_alu        = ALU_ADD;
      case (w_opcode)
         OPC_LOAD: begin
            w_legal      = (w_funct3 != 3'b111);
            w_reg_write  = 1'b1;
            w_alu_src    = 1'b1;
            w_result_src = 2'b01;
         end
         OPC_STORE: begin
            w_legal     = ~w_funct3[2];
            w_mem_write = 1'b1;
            w_alu_src   = 1'b1;
         end
         OPC_BRANCH: begin
            w_branch = 1'b1;
            case (w_funct3)
               3'b000, 3'b001: begin w_legal = 1'b1; w_alu = ALU_SUB;  end
               3'b100, 3'b101: begin w_legal = 1'b1; w_alu = ALU_SLT;  end
               3'b110, 3'b111: begin w_legal = 1'b1; w_alu = ALU_SLTU; end
               default: w_legal = 1'b0;
            endcase
         end
         OPC_JAL: begin
            w_legal      = 1'b1;
            w_reg_write  = 1'b1;
            w_jump       = 1'b1;
            w_result_src = 2'b10;
         end
         OPC_JALR: begin
            w_legal      = (w_funct3 == 3'b000);
            w_reg_write  = 1'b1;
            w_jump       = 1'b1;
            w_jalr       = 1'b1;
            w_alu_src    = 1'b1;
            w_result_src = 2'b10;
         end
         OPC_LUI: begin
            w_legal     = 1'b1;
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            w_alu       = ALU_PASSB;
         end
         OPC_AUIPC: begin
            w_legal     = 1'b1;
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
         end
         OPC_OP: begin
            w_legal     = 1'b1;
            w_reg_write = 1'b1;
            case ({w_funct7, w_funct3})
               10'b0000000_000: w_alu = ALU_ADD;
               10'b0100000_000: w_alu = ALU_SUB;
               10'b0000000_001: w_alu = ALU_SLL;
               10'b0000000_010: w_alu = ALU_SLT;
               10'b0000000_011: w_alu = ALU_SLTU;
               10'b0000000_100: w_alu = ALU_XOR;
               10'b0000000_101: w_alu = ALU_SRL;
               10'b0100000_101: w_alu = ALU_SRA;
               10'b0000000_110: w_alu = ALU_OR;
               10'b0000000_111: w_alu = ALU_AND;
`ifdef ZBA_EN
               10'b0010000_010: w_alu = ALU_SH1ADD;
               10'b0010000_100: w_alu = ALU_SH2ADD;
               10'b0010000_110: w_alu = ALU_SH3ADD;
`endif
               default: w_legal = 1'b0;
            endcase
         end
         OPC_OPIMM: begin
            w_legal     = 1'b1;
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            case (w_funct3)
               3'b000: w_alu = ALU_ADD;
               3'b010: w_alu = ALU_SLT;
               3'b011: w_alu = ALU_SLTU;
               3'b100: w_alu = ALU_XOR;
               3'b110: w_alu = ALU_OR;
               3'b111: w_alu = ALU_AND;
               3'b001: begin
                  w_alu   = ALU_SLL;
                  w_legal = (w_funct6 == 6'b000000);
               end
               default: begin
                  w_alu   = (w_funct6 == 6'b010000) ? ALU_SRA : ALU_SRL;
                  w_legal = (w_funct6 == 6'b000000) || (w_funct6 == 6'b010000);
               end
            endcase
         end
         OPC_OP32: begin
            w_legal     = 1'b1;
            w_reg_write = 1'b1;
            w_word      = 1'b1;
            case ({w_funct7, w_funct3})
               10'b0000000_000: w_alu = ALU_ADD;
               10'b0100000_000: w_alu = ALU_SUB;
               10'b0000000_001: w_alu = ALU_SLL;
               10'b0000000_101: w_alu = ALU_SRL;
               10'b0100000_101: w_alu = ALU_SRA;
`ifdef ZBA_EN
               10'b0000100_000: begin w_alu = ALU_ADDUW;  w_word = 1'b0; end
               10'b0010000_010: begin w_alu = ALU_SH1ADD; w_word = 1'b0; end
               10'b0010000_100: begin w_alu = ALU_SH2ADD; w_word = 1'b0; end
               10'b0010000_110: begin w_alu = ALU_SH3ADD; w_word = 1'b0; end
`endif
               default: w_legal = 1'b0;
            endcase
         end
         OPC_OPIMM32: begin
            w_legal     = 1'b1;
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            w_word      = 1'b1;
            case (w_funct3)
               3'b000: w_alu = ALU_ADD;
               3'b001: begin
                  w_alu   = ALU_SLL;
                  w_legal = (w_funct7 == 7'b0000000);
`ifdef ZBA_EN
                  // slli.uw carries a 6-bit shamt, so only funct6 is fixed.
                  if (w_funct6 == 6'b000010) begin
                     w_legal = 1'b1;
                     w_word  = 1'b0;
                  end
`endif
               end
               3'b101: begin
                  w_alu   = (w_funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                  w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
               end
               default: w_legal = 1'b0;
            endcase
         end
         default: w_legal = 1'b0;
      endcase

      if (!w_legal) begin
         w_reg_write  = 1'b0;
         w_mem_write  = 1'b0;
         w_branch     = 1'b0;
         w_jump       = 1'b0;
         w_jalr       = 1'b0;
         w_alu_src    = 1'b0;
         w_word       = 1'b0;
         w_result_src = 2'b00;
         w_alu        = ALU_ADD;
      end
   end

   always_comb begin
      w_idex            = '0;
      w_idex.rd1        = w_rd1;
      w_idex.rd2        = w_rd2;
      w_idex.imm        = w_imm;
      w_idex.pc         = bus.PC_D;
      w_idex.rs1        = w_rs1;
      w_idex.rs2        = w_rs2;
      w_idex.rd         = w_rd;
      w_idex.reg_write  = w_reg_write;
      w_idex.mem_write  = w_mem_write;
      w_idex.branch     = w_branch;
      w_idex.jump       = w_jump;
      w_idex.jalr       = w_jalr;
      w_idex.alu_src    = w_alu_src;
      w_idex.word       = w_word;
      w_idex.illegal    = ~w_legal;
      w_idex.result_src = w_result_src;
      w_idex.alu_ctrl   = w_alu;
      w_idex.funct3     = w_funct3;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_idex <= '0;
      else if (bus.Flush_E)
         r_idex <= '0;
      else if (!bus.Stall_E)
         r_idex <= w_idex;
   end

   assign bus.RD1_E        = r_idex.rd1;
   assign bus.RD2_E        = r_idex.rd2;
   assign bus.ImmExt_E     = r_idex.imm;
   assign bus.PC_E         = r_idex.pc;
   assign bus.Rs1_E        = r_idex.rs1;
   assign bus.Rs2_E        = r_idex.rs2;
   assign bus.Rd_E         = r_idex.rd;
   assign bus.RegWrite_E   = r_idex.reg_write;
   assign bus.MemWrite_E   = r_idex.mem_write;
   assign bus.Branch_E     = r_idex.branch;
   assign bus.Jump_E       = r_idex.jump;
   assign bus.Jalr_E       = r_idex.jalr;
   assign bus.ALUSrc_E     = r_idex.alu_src;
   assign bus.Word_E       = r_idex.word;
   assign bus.Illegal_E    = r_idex.illegal;
   assign bus.ResultSrc_E  = r_idex.result_src;
   assign bus.ALUControl_E = r_idex.alu_ctrl;
   assign bus.Funct3_E     = r_idex.funct3;
endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: vector table of hand-decoded instructions plus sequences for
// write-through, x0, stall, flush and asynchronous reset.
module tb_decode;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_if u_if ();
   decode u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] imm;
      logic [9:0]  ctl;   // {RegWrite,MemWrite,Branch,Jump,Jalr,ALUSrc,Word,Illegal,ResultSrc[1:0]}
      logic [3:0]  alu;
      logic [4:0]  rd;
      logic [2:0]  f3;
   } vec_t;

   localparam int NVEC = 17;
   vec_t        vt [NVEC];
   logic [63:0] mreg [32];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [287:0] w_all_e;
   logic [9:0]   w_ctl;
   assign w_all_e = {u_if.RD1_E, u_if.RD2_E, u_if.ImmExt_E, u_if.PC_E, u_if.Rs1_E, u_if.Rs2_E,
                     u_if.Rd_E, u_if.RegWrite_E, u_if.MemWrite_E, u_if.Branch_E, u_if.Jump_E,
                     u_if.Jalr_E, u_if.ALUSrc_E, u_if.Word_E, u_if.Illegal_E, u_if.ResultSrc_E,
                     u_if.ALUControl_E, u_if.Funct3_E};
   assign w_ctl = {u_if.RegWrite_E, u_if.MemWrite_E, u_if.Branch_E, u_if.Jump_E, u_if.Jalr_E,
                   u_if.ALUSrc_E, u_if.Word_E, u_if.Illegal_E, u_if.ResultSrc_E};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string name);
      n_checks++;
      if (w_all_e !== '0) begin
         n_fail++;
         $display("FAIL %s: _E outputs %h expected all zero", name, w_all_e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vt[0]  = '{32'h00500093, 64'd5,                  10'b1000_0100_00, 4'b0000, 5'd1,  3'd0};
      vt[1]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 10'b0010_0000_00, 4'b0001, 5'd29, 3'd0};
      vt[2]  = '{32'h00812283, 64'd8,                  10'b1000_0100_01, 4'b0000, 5'd5,  3'd2};
      vt[3]  = '{32'hFE513C23, 64'hFFFF_FFFF_FFFF_FFF8, 10'b0100_0100_00, 4'b0000, 5'd24, 3'd3};
      vt[4]  = '{32'h001000EF, 64'h800,                10'b1001_0000_10, 4'b0000, 5'd1,  3'd0};
      vt[5]  = '{32'h00008067, 64'd0,                  10'b1001_1100_10, 4'b0000, 5'd0,  3'd0};
      vt[6]  = '{32'h80000537, 64'hFFFF_FFFF_8000_0000, 10'b1000_0100_00, 4'b1110, 5'd10, 3'd0};
      vt[7]  = '{32'h00001197, 64'h1000,               10'b1000_0100_00, 4'b0000, 5'd3,  3'd1};
      vt[8]  = '{32'h402081B3, 64'd0,                  10'b1000_0000_00, 4'b0001, 5'd3,  3'd0};
      vt[9]  = '{32'h43F25213, 64'h43F,                10'b1000_0100_00, 4'b1001, 5'd4,  3'd5};
      vt[10] = '{32'h007302BB, 64'd0,                  10'b1000_0010_00, 4'b0000, 5'd5,  3'd0};
      vt[11] = '{32'h4030D09B, 64'h403,                10'b1000_0110_00, 4'b1001, 5'd1,  3'd5};
      vt[12] = '{32'h00000000, 64'd0,                  10'b0000_0001_00, 4'b0000, 5'd0,  3'd0};
      vt[13] = '{32'h00007083, 64'd0,                  10'b0000_0001_00, 4'b0000, 5'd1,  3'd7};
`ifdef ZBA_EN
      vt[14] = '{32'h207342B3, 64'd0,                  10'b1000_0000_00, 4'b1011, 5'd5,  3'd4};
      vt[15] = '{32'h087302BB, 64'd0,                  10'b1000_0000_00, 4'b1101, 5'd5,  3'd0};
      vt[16] = '{32'h0831109B, 64'h83,                 10'b1000_0100_00, 4'b0111, 5'd1,  3'd1};
`else
      vt[14] = '{32'h207342B3, 64'd0,                  10'b0000_0001_00, 4'b0000, 5'd5,  3'd4};
      vt[15] = '{32'h087302BB, 64'd0,                  10'b0000_0001_00, 4'b0000, 5'd5,  3'd0};
      vt[16] = '{32'h0831109B, 64'h83,                 10'b0000_0001_00, 4'b0000, 5'd1,  3'd1};
`endif

      rst             = 1'b1;
      u_if.PC_D       = '0;
      u_if.Instr_D    = 32'h00000013;
      u_if.Flush_E    = 1'b0;
      u_if.Stall_E    = 1'b0;
      u_if.RegWrite_W = 1'b0;
      u_if.Rd_W       = '0;
      u_if.Result_W   = '0;
      step();
      step();
      chk_zero("reset_state");
      rst = 1'b0;

      mreg[0] = '0;
      for (int i = 1; i < 32; i++) begin
         mreg[i]         = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0000_0001_0000_0101;
         u_if.RegWrite_W = 1'b1;
         u_if.Rd_W       = 5'(i);
         u_if.Result_W   = mreg[i];
         step();
      end
      u_if.RegWrite_W = 1'b0;

      for (int k = 0; k < NVEC; k++) begin
         u_if.Instr_D = vt[k].instr;
         u_if.PC_D    = 64'h1000 + 64'(k * 4);
         #1;
         chk($sformatf("v%0d.rs1_d", k), 64'(u_if.Rs1_D), 64'(vt[k].instr[19:15]));
         chk($sformatf("v%0d.rs2_d", k), 64'(u_if.Rs2_D), 64'(vt[k].instr[24:20]));
         step();
         chk($sformatf("v%0d.imm", k), u_if.ImmExt_E, vt[k].imm);
         chk($sformatf("v%0d.ctl", k), 64'(w_ctl), 64'(vt[k].ctl));
         chk($sformatf("v%0d.alu", k), 64'(u_if.ALUControl_E), 64'(vt[k].alu));
         chk($sformatf("v%0d.rd", k), 64'(u_if.Rd_E), 64'(vt[k].rd));
         chk($sformatf("v%0d.f3", k), 64'(u_if.Funct3_E), 64'(vt[k].f3));
         chk($sformatf("v%0d.pc", k), u_if.PC_E, 64'h1000 + 64'(k * 4));
         chk($sformatf("v%0d.rs1_e", k), 64'(u_if.Rs1_E), 64'(vt[k].instr[19:15]));
         chk($sformatf("v%0d.rs2_e", k), 64'(u_if.Rs2_E), 64'(vt[k].instr[24:20]));
         chk($sformatf("v%0d.rd1", k), u_if.RD1_E, mreg[vt[k].instr[19:15]]);
         chk($sformatf("v%0d.rd2", k), u_if.RD2_E, mreg[vt[k].instr[24:20]]);
      end

      // add x3,x2,x2 while x2 is being written back
      u_if.Instr_D    = 32'h002101B3;
      u_if.RegWrite_W = 1'b1;
      u_if.Rd_W       = 5'd2;
      u_if.Result_W   = 64'hDEAD;
      step();
      chk("wt_rd1", u_if.RD1_E, 64'hDEAD);
      chk("wt_rd2", u_if.RD2_E, 64'hDEAD);
      mreg[2]         = 64'hDEAD;
      u_if.RegWrite_W = 1'b0;
      step();
      chk("wt_stored", u_if.RD1_E, mreg[2]);

      // writes to x0 neither bypass nor stick
      u_if.Instr_D    = 32'h000001B3;
      u_if.RegWrite_W = 1'b1;
      u_if.Rd_W       = 5'd0;
      u_if.Result_W   = 64'hBAD;
      step();
      chk("x0_bypass_rd1", u_if.RD1_E, 64'd0);
      chk("x0_bypass_rd2", u_if.RD2_E, 64'd0);
      u_if.RegWrite_W = 1'b0;
      step();
      chk("x0_stored", u_if.RD1_E, 64'd0);

      u_if.Instr_D = 32'h002101B3;
      u_if.Flush_E = 1'b1;
      u_if.Stall_E = 1'b1;
      step();
      chk("flush_stall_regwrite", 64'(u_if.RegWrite_E), 64'd0);
      chk_zero("flush_stall_bubble");
      u_if.Stall_E = 1'b0;
      u_if.Instr_D = 32'h00500093;
      step();
      chk_zero("flush_bubble");
      u_if.Flush_E = 1'b0;

      u_if.PC_D = 64'h100;
      step();
      chk("pre_stall_imm", u_if.ImmExt_E, 64'd5);
      u_if.Stall_E    = 1'b1;
      u_if.Instr_D    = 32'h402081B3;
      u_if.PC_D       = 64'h300;
      u_if.RegWrite_W = 1'b1;
      u_if.Rd_W       = 5'd9;
      u_if.Result_W   = 64'h99;
      step();
      chk("stall_imm", u_if.ImmExt_E, 64'd5);
      chk("stall_pc", u_if.PC_E, 64'h100);
      chk("stall_alu", 64'(u_if.ALUControl_E), 64'd0);
      chk("stall_rd", 64'(u_if.Rd_E), 64'd1);
      u_if.RegWrite_W = 1'b0;
      step();
      chk("stall2_pc", u_if.PC_E, 64'h100);
      chk("stall2_ctl", 64'(w_ctl), 64'(10'b1000_0100_00));
      u_if.Stall_E = 1'b0;
      u_if.Instr_D = 32'h000481B3;
      mreg[9]      = 64'h99;
      step();
      chk("stall_write_rd1", u_if.RD1_E, mreg[9]);
      chk("post_stall_pc", u_if.PC_E, 64'h300);

      // add x3,x1,x1 then reset asynchronously between clock edges
      u_if.Instr_D = 32'h001081B3;
      step();
      chk("pre_reset_rd1", u_if.RD1_E, mreg[1]);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_reset");
      u_if.RegWrite_W = 1'b1;
      u_if.Rd_W       = 5'd5;
      u_if.Result_W   = 64'h55;
      step();
      step();
      chk_zero("held_reset");
      rst             = 1'b0;
      u_if.RegWrite_W = 1'b0;
      u_if.Instr_D    = 32'h00500093;
      u_if.PC_D       = 64'h200;
      step();
      chk("post_reset_pc", u_if.PC_E, 64'h200);
      chk("post_reset_imm", u_if.ImmExt_E, 64'd5);
      for (int i = 1; i < 32; i++) begin
         u_if.Instr_D = 32'h000001B3 | (32'(i) << 15);
         step();
         chk($sformatf("reset_x%0d", i), u_if.RD1_E, 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port PC_D, input, 64 bits: PC of the instruction in Decode.
REQ-004 SHALL have port Instr_D, input, 32 bits: instruction word in Decode.
REQ-005 SHALL have port Flush_E, input, 1 bit: load a bubble into ID/EX.
REQ-006 SHALL have port Stall_E, input, 1 bit: hold ID/EX contents.
REQ-007 SHALL have writeback inputs: RegWrite_W (1 bit, write enable), Rd_W (5 bits, destination), Result_W (64 bits, write data).
REQ-008 SHALL have port Rs1_D, output, 5 bits, combinational: Instr_D[19:15], for the hazard unit.
REQ-009 SHALL have port Rs2_D, output, 5 bits, combinational: Instr_D[24:20], for the hazard unit.
REQ-010 SHALL have registered 64-bit ID/EX outputs: RD1_E, RD2_E, ImmExt_E, PC_E.
REQ-011 SHALL have registered 5-bit ID/EX outputs: Rs1_E, Rs2_E, Rd_E.
REQ-012 SHALL have registered 1-bit ID/EX outputs: RegWrite_E, MemWrite_E, Branch_E, Jump_E, Jalr_E, ALUSrc_E, Word_E, Illegal_E.
REQ-013 SHALL have registered multi-bit ID/EX outputs: ResultSrc_E (2 bits: 00 ALU, 01 mem, 10 PC+4), ALUControl_E (4 bits), Funct3_E (3 bits).

Function
REQ-014 SHALL contain a register file of 32 x 64 bits, written on the rising clk edge when RegWrite_W=1 and Rd_W!=0.
REQ-015 SHALL read x0 as 0 always; writes to x0 are ignored.
REQ-016 SHALL provide write-through reads: same-cycle RegWrite_W with Rd_W==rs (rs!=0) returns Result_W.
REQ-017 SHALL generate immediates for I, S, B, U and J formats, sign-extended to 64 bits; B and J immediates have bit 0 = 0; U immediate = {sext(imm[31:12]),12'b0}.
REQ-018 SHALL decode opcodes: LOAD, STORE, OP, OP-IMM, OP-32, OP-IMM-32, BRANCH, JAL, JALR, LUI, AUIPC.
REQ-019 SHALL set Word_E=1 for OP-32 and OP-IMM-32 instructions.
REQ-020 SHALL encode ALUControl as: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, SH1ADD 1010, SH2ADD 1011, SH3ADD 1100, ADD.UW 1101, PASSB 1110.
REQ-021 SHALL decode LUI as PASSB with ALUSrc=1, and AUIPC as ADD (PC + imm is computed by Execute).
REQ-022 SHALL treat an unrecognised encoding as Illegal_E=1, with RegWrite_E=MemWrite_E=Branch_E=Jump_E=0.
REQ-023 SHALL give a latency of 1 cycle: the Decode inputs at edge N appear on the _E outputs after edge N.
REQ-024 SHALL, on Flush_E=1, load a bubble into ID/EX: all _E outputs 0 (behaves as NOP).
REQ-025 SHALL, on Stall_E=1 with Flush_E=0, hold all _E outputs unchanged; register-file writes still occur.
REQ-026 SHALL give Flush_E priority over Stall_E when both are asserted.

Reset
REQ-027 SHALL, while rst=1, force all _E outputs to 0 and all 32 registers to 0, asynchronously.
REQ-028 SHALL ignore any writeback during rst=1; on the first edge after deassertion it latches the current Decode inputs.

Configuration
REQ-029 SHALL, with ZBA_EN defined, decode the Zba instructions: sh1add, sh2add, sh3add (OP, funct7 0010000); add.uw, sh1add.uw, sh2add.uw, sh3add.uw (OP-32 with Word_E=0); slli.uw (OP-IMM-32, funct6 000010).
REQ-030 SHALL, with ZBA_EN undefined, flag all of those encodings Illegal_E=1 and use no Zba decode logic.

Verification
REQ-031 SHALL cover: rst=1 mid-run with nonzero RD1_E -> all _E outputs and x1..x31 read 0 immediately.
REQ-032 SHALL cover: Instr_D=0x00500093 (addi x1,x0,5), PC_D=0x100 -> next cycle ImmExt_E=5, ALUSrc_E=1, RegWrite_E=1, Rd_E=1, ALUControl_E=0000, PC_E=0x100.
REQ-033 SHALL cover: RegWrite_W=1, Rd_W=2, Result_W=0xDEAD in the same cycle as add x3,x2,x2 in Decode -> RD1_E=RD2_E=0xDEAD.
REQ-034 SHALL cover: Instr_D=0xFE000EE3 (beq x0,x0,-4) -> ImmExt_E=0xFFFF_FFFF_FFFF_FFFC, Branch_E=1, Funct3_E=000.
REQ-035 SHALL cover: Flush_E=1 and Stall_E=1 together with a valid add in Decode -> RegWrite_E=0 and all _E outputs 0.
REQ-036 SHALL cover: sh2add x5,x6,x7 -> ALUControl_E=1011 with ZBA_EN defined; Illegal_E=1 and RegWrite_E=0 without ZBA_EN.
